// File: rtl/if_id_buffer_if.sv
// Fetch-to-decode bundle: enqueue side, dequeue side, flush and occupancy.
// Latency: none (wires only).
// Backpressure: in_ready toward fetch, out_ready from decode.
interface if_id_buffer_if #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 64,
    parameter int INST_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic [ADDR_W-1:0] in_pc;
    logic [INST_W-1:0] in_inst;
    logic              in_ready;
    logic              out_valid;
    logic [ADDR_W-1:0] out_pc;
    logic [INST_W-1:0] out_inst;
    logic [2:0]        out_class;
    logic              out_ready;
    logic              flush;
    logic [CNT_W-1:0]  count;

    // Fetch/decode side (drives requests, observes buffer state).
    modport master (
        output in_valid, in_pc, in_inst, out_ready, flush,
        input  in_ready, out_valid, out_pc, out_inst, out_class, count
    );

    // Buffer side.
    modport slave (
        input  in_valid, in_pc, in_inst, out_ready, flush,
        output in_ready, out_valid, out_pc, out_inst, out_class, count
    );
endinterface

// File: rtl/if_id_buffer.sv
// Two-entry elastic IF/ID buffer storing {pc, inst, class}, with single-cycle flush.
// Latency: one cycle from enqueue edge to out_*; no combinational bypass.
// Backpressure: in_ready depends only on registered count (no enqueue when full, even with a dequeue).
module if_id_buffer #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 64,
    parameter int INST_W = 32
) (
    input logic          clk,
    input logic          rst,
    if_id_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [INST_W-1:0] inst_q [DEPTH];
    logic [2:0]        cls_q  [DEPTH];

    logic enq;
    logic deq;
    logic [2:0] in_class;

    // Coarse decode of the major opcode; non-32-bit encodings fall into OTHER.
    function automatic logic [2:0] classify(input logic [6:0] op);
        logic [2:0] c;
        if (op[1:0] != 2'b11) begin
            c = 3'd7;
        end else begin
            case (op)
                7'b0110011, 7'b0111011: c = 3'd0;
                7'b0010011, 7'b0011011: c = 3'd1;
                7'b0000011:             c = 3'd2;
                7'b0100011:             c = 3'd3;
                7'b1100011:             c = 3'd4;
                7'b1101111, 7'b1100111: c = 3'd5;
                7'b0110111, 7'b0010111: c = 3'd6;
                default:                c = 3'd7;
            endcase
        end
        return c;
    endfunction

    assign in_class      = classify(bus.in_inst[6:0]);
    assign bus.in_ready  = (count_q != CNT_W'(DEPTH));
    assign bus.out_valid = (count_q != '0);
    assign bus.out_pc    = pc_q[rd_ptr_q];
    assign bus.out_inst  = inst_q[rd_ptr_q];
    assign bus.out_class = cls_q[rd_ptr_q];
    assign bus.count     = count_q;

    assign enq = bus.in_valid  && bus.in_ready  && !bus.flush;
    assign deq = bus.out_valid && bus.out_ready && !bus.flush;

    // Next pointer/occupancy; flush overrides any enqueue or dequeue.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; reset seeds a NOP so the idle head reads pc=0, class ALU-I.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= NOP_INST;
                cls_q[i]  <= 3'd1;
            end
        end else if (enq) begin
            pc_q[wr_ptr_q]   <= bus.in_pc;
            inst_q[wr_ptr_q] <= bus.in_inst;
            cls_q[wr_ptr_q]  <= in_class;
        end
    end
endmodule

// File: tb/tb_if_id_buffer.sv
// Randomized + directed bench for if_id_buffer against a queue-based model.
// Latency: checks outputs 2ns after every rising edge.
// Backpressure: model accepts only while its queue is below depth.
module tb_if_id_buffer;
    localparam int DEPTH = 2;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;
    ent_t q[$];

    if_id_buffer_if #(.DEPTH(DEPTH), .ADDR_W(64), .INST_W(32)) bus ();

    if_id_buffer #(.DEPTH(DEPTH), .ADDR_W(64), .INST_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_class(input logic [31:0] inst);
        logic [6:0] op;
        op = inst[6:0];
        if (inst[1:0] != 2'b11)           return 3'd7;
        if (op == 7'h33 || op == 7'h3B)   return 3'd0;
        if (op == 7'h13 || op == 7'h1B)   return 3'd1;
        if (op == 7'h03)                  return 3'd2;
        if (op == 7'h23)                  return 3'd3;
        if (op == 7'h63)                  return 3'd4;
        if (op == 7'h6F || op == 7'h67)   return 3'd5;
        if (op == 7'h37 || op == 7'h17)   return 3'd6;
        return 3'd7;
    endfunction

    // Model update at each edge / async reset, then compare every output.
    initial begin
        logic        hold;
        logic [63:0] h_pc;
        logic [31:0] h_inst;
        logic [2:0]  h_cls;
        forever begin
            @(posedge clk or posedge rst);
            hold = 1'b0;
            if (rst) begin
                q.delete();
            end else begin
                logic can_in;
                logic do_enq;
                logic do_deq;
                can_in = (q.size() != DEPTH);
                do_enq = bus.in_valid && can_in && !bus.flush;
                do_deq = (q.size() != 0) && bus.out_ready && !bus.flush;
                if (q.size() != 0 && !bus.out_ready && !bus.flush) begin
                    hold   = 1'b1;
                    h_pc   = bus.out_pc;
                    h_inst = bus.out_inst;
                    h_cls  = bus.out_class;
                end
                if (bus.flush) begin
                    q.delete();
                end else begin
                    ent_t e;
                    e.pc   = bus.in_pc;
                    e.inst = bus.in_inst;
                    if (do_deq) void'(q.pop_front());
                    if (do_enq) q.push_back(e);
                end
            end
            #2;
            check("count", 64'(bus.count), 64'(q.size()));
            check("count_le_depth", 64'(bus.count <= DEPTH), 64'd1);
            check("in_ready", 64'(bus.in_ready), 64'(q.size() != DEPTH));
            check("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
            if (q.size() != 0) begin
                check("out_pc", bus.out_pc, q[0].pc);
                check("out_inst", 64'(bus.out_inst), 64'(q[0].inst));
                check("out_class", 64'(bus.out_class), 64'(ref_class(q[0].inst)));
            end
            if (hold && !rst) begin
                check("hold_pc", bus.out_pc, h_pc);
                check("hold_inst", 64'(bus.out_inst), 64'(h_inst));
                check("hold_class", 64'(bus.out_class), 64'(h_cls));
            end
        end
    end

    task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                         input logic ordy, input logic fl);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_inst   = inst;
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    localparam logic [31:0] ADDI = 32'h0050_0093;

    initial begin
        logic [31:0] cls_inst [6];
        logic [2:0]  cls_exp  [6];
        logic [6:0]  ops      [12];
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_inst   = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        cls_inst = '{32'h0000_a083, 32'h0011_3023, 32'hfe00_08e3,
                     32'h0000_006f, 32'h0000_0537, 32'h0000_0000};
        cls_exp  = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        ops      = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h23,
                     7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0B};

        // Reset values.
        repeat (2) @(posedge clk);
        #2;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_out_pc", bus.out_pc, 64'd0);
        check("rst_out_inst", 64'(bus.out_inst), 64'h13);
        check("rst_out_class", 64'(bus.out_class), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // Single entry, then one-per-cycle streaming.
        drive(1, 64'h8000_0000, ADDI, 1, 0);
        tick();
        check("t1_valid", 64'(bus.out_valid), 64'd1);
        check("t1_pc", bus.out_pc, 64'h8000_0000);
        check("t1_class", 64'(bus.out_class), 64'd1);
        check("t1_count", 64'(bus.count), 64'd1);
        for (int i = 1; i <= 3; i++) begin
            drive(1, 64'h8000_0000 + 64'(4 * i), ADDI, 1, 0);
            tick();
            check("t1_stream_count", 64'(bus.count), 64'd1);
            check("t1_stream_pc", bus.out_pc, 64'h8000_0000 + 64'(4 * i));
        end
        drive(0, 0, 0, 1, 0);
        tick();
        check("t1_drain", 64'(bus.count), 64'd0);

        // Fill under stall, refused third, ordered drain.
        drive(1, 64'h8000_0000, ADDI, 0, 0);
        tick();
        drive(1, 64'h8000_0004, ADDI, 0, 0);
        tick();
        check("t2_full_count", 64'(bus.count), 64'd2);
        check("t2_full_rdy", 64'(bus.in_ready), 64'd0);
        check("t2_head", bus.out_pc, 64'h8000_0000);
        drive(1, 64'h8000_0008, ADDI, 0, 0);
        tick();
        check("t2_refused", 64'(bus.count), 64'd2);
        drive(0, 0, 0, 1, 0);
        tick();
        check("t2_second", bus.out_pc, 64'h8000_0004);
        check("t2_rdy_back", 64'(bus.in_ready), 64'd1);
        tick();
        check("t2_empty", 64'(bus.out_valid), 64'd0);

        // Concurrent enqueue/dequeue at count=1 with pointer wrap.
        drive(1, 64'h8000_0040, ADDI, 1, 0);
        tick();
        for (int i = 1; i <= 8; i++) begin
            drive(1, 64'h8000_0040 + 64'(4 * i), ADDI, 1, 0);
            tick();
            check("t3_count", 64'(bus.count), 64'd1);
            check("t3_pc", bus.out_pc, 64'h8000_0040 + 64'(4 * i));
        end
        drive(0, 0, 0, 1, 0);
        tick();

        // Flush with a simultaneous in_valid.
        drive(1, 64'h8000_0080, ADDI, 0, 0);
        tick();
        drive(1, 64'h8000_0084, ADDI, 0, 0);
        tick();
        drive(1, 64'h8000_0100, ADDI, 0, 1);
        tick();
        check("t4_count", 64'(bus.count), 64'd0);
        check("t4_valid", 64'(bus.out_valid), 64'd0);
        check("t4_rdy", 64'(bus.in_ready), 64'd1);
        drive(0, 0, 0, 1, 0);
        tick();
        check("t4_dropped", 64'(bus.out_valid), 64'd0);

        // Class encoding.
        for (int i = 0; i < 6; i++) begin
            drive(1, 64'h8000_0200 + 64'(4 * i), cls_inst[i], 1, 0);
            tick();
            check("t5_class", 64'(bus.out_class), 64'(cls_exp[i]));
            check("t5_inst", 64'(bus.out_inst), 64'(cls_inst[i]));
        end
        drive(0, 0, 0, 1, 0);
        tick();

        // Asynchronous reset between edges with a full buffer.
        drive(1, 64'h8000_0300, ADDI, 0, 0);
        tick();
        drive(1, 64'h8000_0304, ADDI, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("t6_valid", 64'(bus.out_valid), 64'd0);
        check("t6_count", 64'(bus.count), 64'd0);
        check("t6_pc", bus.out_pc, 64'd0);
        check("t6_inst", 64'(bus.out_inst), 64'h13);
        check("t6_rdy", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 64'h8000_0400, ADDI, 0, 0);
        tick();
        check("t6_resume_pc", bus.out_pc, 64'h8000_0400);
        check("t6_resume_count", 64'(bus.count), 64'd1);

        // Random traffic checked by the model.
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] inst;
            logic [63:0] pc;
            inst      = $urandom;
            if ($urandom_range(0, 7) != 0) inst[6:0] = ops[$urandom_range(0, 11)];
            pc        = {32'h0, $urandom} << 2;
            drive(($urandom_range(0, 3) != 0), pc, inst,
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0));
        end
        drive(0, 0, 0, 1, 0);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
